ram_port_arbiter: RTL and testbench

Shares the single RAM port (10-bit address, 32-bit data, synchronous read) between the core datapath and a debug/loader requester. It lets a host load programs and inspect data memory while the processor runs. The block sits between the datapath's memory signals and the RAM instance, and stalls the core whenever the debug side owns the port. CPU accesses pass through combinationally. Debug accesses use a registered request/grant handshake.

---
 rtl/ram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM port between the core datapath and a debug/loader requester.
// Define ARB_STARVE_GUARD_EN to force a debug access in after STARVE_MAX contended CPU cycles.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StCpu, StDbg, StDrd} state_e;

  state_e              state_q, state_d;
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                starve_fire;
  logic                take;

  assign take = (state_q == StCpu) && dbg_req && (!cpu_req || starve_fire);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign starve_fire = (starve_q == CntW'(STARVE_MAX));

  // Counts consecutive S_CPU cycles where the CPU beat a waiting debug request; saturates.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StCpu) begin
      if (take || !dbg_req) begin
        starve_d = '0;
      end else if (cpu_req && !starve_fire) begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCpu:   if (take) state_d = StDbg;
      StDbg:   state_d = lat_we_q ? StCpu : StDrd;
      StDrd:   state_d = StCpu;
      default: state_d = StCpu;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_write = cpu_req & cpu_we;
    if (state_q != StCpu) begin
      ram_addr  = lat_addr_q;
      ram_wdata = lat_wdata_q;
      ram_write = (state_q == StDbg) & lat_we_q;
    end
  end

  assign cpu_stall  = cpu_req & (state_q != StCpu);
  assign cpu_rdata  = ram_rdata;
  assign dbg_gnt    = (state_q == StDbg);
  assign dbg_rdata  = rdata_q;
  assign dbg_rvalid = rvalid_q;

  // A write sitting in StDbg at a reset edge still commits: ram_write does not look at reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StCpu;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= (state_q == StDrd);
      if (state_q == StDrd) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (take) begin
      lat_we_q    <= dbg_we;
      lat_addr_q  <= dbg_addr;
      lat_wdata_q <= dbg_wdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter; follows ARB_STARVE_GUARD_EN like the DUT.
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic              clock, reset_n;
  logic              cpu_req, cpu_we, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  ram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dreq_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_val;
  } exp_t;

  dreq_t             dq[$];
  exp_t              exp_q[$];
  logic [DATA_W-1:0] rd_q[$];
  logic [DATA_W-1:0] ref_mem[1024];
  logic [DATA_W-1:0] mem[1024];

  // Reference model: debug ownership is a count of remaining owned cycles.
  int unsigned       m_own, m_run;
  logic              m_first, m_rvalid, m_prev_ok;
  dreq_t             m_lat;
  logic [DATA_W-1:0] m_rdata, m_prev_rd;
  int unsigned       n_tests, n_fail;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Environment RAM: synchronous read returning pre-write contents.
  initial begin
    logic [DATA_W-1:0] rd;
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      rd = mem[ram_addr];
      if (ram_write) mem[ram_addr] = ram_wdata;
      ram_rdata <= rd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic creq, input logic cwe,
                      input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwd);
    exp_t e;
    logic take;
    @(posedge clock);
    #1;
    reset_n   = rstn;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwd;
    if (dq.size() > 0) begin
      dbg_req   = 1'b1;
      dbg_we    = dq[0].we;
      dbg_addr  = dq[0].addr;
      dbg_wdata = dq[0].data;
    end else begin
      dbg_req   = 1'b0;
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_addr  = 10'($urandom);
      dbg_wdata = $urandom;
    end
    if (m_own == 0) begin
      e.addr = caddr; e.write = creq & cwe; e.wdata = cwd; e.stall = 1'b0; e.gnt = 1'b0;
    end else begin
      e.addr  = m_lat.addr;
      e.write = m_first & m_lat.we;
      e.wdata = m_lat.data;
      e.stall = creq;
      e.gnt   = m_first;
    end
    e.rvalid = m_rvalid;
    e.rdata  = m_rdata;
    e.rd_ok  = m_prev_ok;
    e.rd_val = m_prev_rd;
    exp_q.push_back(e);
    m_prev_ok = 1'b1;
    m_prev_rd = ref_mem[e.addr];
    if (e.write) ref_mem[e.addr] = e.wdata;

    take = (m_own == 0) && dbg_req && (!creq || (Guard && m_run >= STARVE_MAX));
    if (!rstn) begin
      if (m_own > 0 && !m_lat.we) void'(rd_q.pop_back());
      m_own = 0; m_first = 1'b0; m_run = 0; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      m_rvalid = (m_own == 1) && !m_lat.we;
      if (m_rvalid) m_rdata = ref_mem[m_lat.addr];
      if (m_own > 0) begin
        m_own--;
        m_first = 1'b0;
      end else begin
        if (take || !dbg_req) m_run = 0;
        else if (creq && m_run < STARVE_MAX) m_run++;
        if (take) begin
          m_lat   = dq.pop_front();
          m_own   = m_lat.we ? 1 : 2;
          m_first = 1'b1;
          if (!m_lat.we) rd_q.push_back(ref_mem[m_lat.addr]);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ram_addr", 32'(ram_addr), 32'(e.addr));
      check("ram_write", 32'(ram_write), 32'(e.write));
      if (e.write) check("ram_wdata", ram_wdata, e.wdata);
      check("cpu_stall", 32'(cpu_stall), 32'(e.stall));
      check("dbg_gnt", 32'(dbg_gnt), 32'(e.gnt));
      check("dbg_rvalid", 32'(dbg_rvalid), 32'(e.rvalid));
      check("dbg_rdata_reg", dbg_rdata, e.rdata);
      if (e.rd_ok) check("cpu_rdata", cpu_rdata, e.rd_val);
    end
    if (dbg_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dbg_rvalid_unexpected: got 1, expected 0");
      end else begin
        check("dbg_read_data", dbg_rdata, rd_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    m_own = 0; m_run = 0; m_first = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_prev_ok = 1'b0; m_prev_rd = '0;
    m_lat = '{we: 1'b0, addr: '0, data: '0};
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // CPU-only write then read-back
    step(1'b1, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, 10'h005, '0);
    idle(1);

    // Debug write with the CPU idle
    dq.push_back('{we: 1'b1, addr: 10'h3FF, data: 32'h1234_5678});
    idle(4);

    // Contended debug read of 0x010
    step(1'b1, 1'b1, 1'b1, 10'h010, 32'hCAFE_F00D);
    dq.push_back('{we: 1'b0, addr: 10'h010, data: '0});
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 10'($urandom_range(0, 31)), '0);
    idle(5);

    // Back-to-back debug writes
    for (int k = 0; k < 3; k++) dq.push_back('{we: 1'b1, addr: 10'(10'h100 + k), data: $urandom});
    idle(8);

    // Reset in the read-data cycle of a debug read
    dq.push_back('{we: 1'b0, addr: 10'h3FF, data: '0});
    idle(2);
    step(1'b0, 1'b1, 1'b0, 10'h001, '0);
    step(1'b1, 1'b1, 1'b0, 10'h002, '0);
    idle(2);

    // Reset while a debug write holds the port; the write still lands
    dq.push_back('{we: 1'b1, addr: 10'h020, data: 32'h0BAD_F00D});
    idle(1);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 10'h020, '0);
    idle(2);

    for (int c = 0; c < 800; c++) begin
      if (dq.size() < 2 && $urandom_range(0, 99) < 20)
        dq.push_back('{we: 1'($urandom_range(0, 1)), addr: 10'($urandom_range(0, 31)),
                       data: $urandom});
      step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom);
    end
    idle(12);
    @(negedge clock);
    #1;
    check("read_scoreboard_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
